// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: EX/MEM request fields, data-memory bus and pipeline control of the MEM stage
interface mem_access_stage_if #(parameter int ADDR_W = 32);
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [31:0]       Addr_i;
  logic [31:0]       WriteData_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;
  logic [31:0]       MemData_o;
  logic              stall_o;
  logic              err_o;
  modport master (
    input  MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, MemData_o, stall_o, err_o
  );
  modport slave (
    output MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, MemData_o, stall_o, err_o
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage req/ack data-memory controller with pipeline stall; MEM_LAST_BUF_EN adds a last-access read buffer
module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk_i,
  input logic rst_i,
  mem_access_stage_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state, w_next;
  logic [15:0]       r_cnt;
  logic              r_req, r_we, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_md;
  logic              w_access, w_mis, w_hit, w_ack, w_to, w_start, w_stall;
  logic [31:0]       w_hit_data;
  assign w_access = bus.MemRead_i | bus.MemWrite_i;
  assign w_mis    = bus.Addr_i[1:0] != 2'b00;
  assign w_ack    = r_state == BUSY && bus.mem_ack_i;
  assign w_to     = r_state == BUSY && !bus.mem_ack_i && r_cnt == 16'(TIMEOUT - 1);
  assign w_start  = r_state == IDLE && w_access && !w_mis && !w_hit;
`ifdef MEM_LAST_BUF_EN
  logic [ADDR_W-1:0] r_tag;
  logic [31:0]       r_bdata;
  logic              r_valid;
  assign w_hit      = !bus.MemWrite_i && bus.MemRead_i && r_valid && r_tag == bus.Addr_i[ADDR_W-1:0];
  assign w_hit_data = r_bdata;
  // remember the last completed access; a timeout leaves memory contents unknown
  always_ff @(posedge clk_i) begin
    if (rst_i || w_to) r_valid <= 1'b0;
    else if (w_ack) begin
      r_tag   <= r_addr;
      r_bdata <= r_we ? r_wdata : bus.mem_rdata_i;
      r_valid <= 1'b1;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'd0;
`endif
  // state register
  always_ff @(posedge clk_i) begin
    r_state <= rst_i ? IDLE : w_next;
  end
  // next state and combinational stall
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: if (w_access) w_next = (w_mis || w_hit) ? DONE : BUSY;
      BUSY: if (w_ack || w_to) w_next = DONE;
      default: w_next = IDLE;
    endcase
    w_stall = !rst_i && ((r_state == IDLE && w_access) || r_state == BUSY);
  end
  // memory request, timeout counter, error pulse and load result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_md    <= '0;
    end else begin
      r_err <= (r_state == IDLE && w_access && w_mis) || w_to;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= bus.MemWrite_i;
        r_addr  <= bus.Addr_i[ADDR_W-1:0];
        r_wdata <= bus.WriteData_i;
        r_cnt   <= '0;
      end else if (w_ack || w_to) r_req <= 1'b0;
      else if (r_state == BUSY) r_cnt <= r_cnt + 16'd1;
      if (w_to) r_md <= '0;
      else if (w_ack && !r_we) r_md <= bus.mem_rdata_i;
      else if (r_state == IDLE && w_access && !w_mis && w_hit) r_md <= w_hit_data;
    end
  end
  assign bus.mem_req_o   = r_req;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.MemData_o   = r_md;
  assign bus.stall_o     = w_stall;
  assign bus.err_o       = r_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the MEM-stage access controller (TIMEOUT=4)
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int req_cycles, stall_cycles, err_cycles;
  logic done_seen, we_seen, done_err;
  logic [31:0] addr_seen, wdata_seen, done_md;
  mem_access_stage_if #(.ADDR_W(32)) bus ();
  mem_access_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd_data);
    int k = 0;
    int rq = 0;
    req_cycles = 0; stall_cycles = 0; err_cycles = 0;
    done_seen = 1'b0; we_seen = 1'b0; done_err = 1'b0;
    addr_seen = '0; wdata_seen = '0; done_md = '0;
    @(posedge clk); #1;
    bus.MemRead_i = rd; bus.MemWrite_i = wr; bus.Addr_i = a; bus.WriteData_i = wd;
    @(negedge clk);
    stall_cycles += int'(bus.stall_o);
    req_cycles   += int'(bus.mem_req_o);
    err_cycles   += int'(bus.err_o);
    while (!done_seen && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (bus.mem_req_o) rq++;
      bus.mem_ack_i   = ack_at > 0 && bus.mem_req_o && rq == ack_at;
      bus.mem_rdata_i = bus.mem_ack_i ? rd_data : 32'h0;
      @(negedge clk);
      stall_cycles += int'(bus.stall_o);
      err_cycles   += int'(bus.err_o);
      if (bus.mem_req_o) begin
        req_cycles++;
        we_seen = bus.mem_we_o; addr_seen = bus.mem_addr_o; wdata_seen = bus.mem_wdata_o;
      end
      if (!bus.stall_o) begin
        done_seen = 1'b1; done_md = bus.MemData_o; done_err = bus.err_o;
      end
    end
    @(posedge clk); #1;
    bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.mem_req_o); end
    n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.mem_we_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata_o); end
    n_cmp++; if (bus.MemData_o !== 32'h0) begin n_err++; $display("FAIL reset_memdata: got %h want 0", bus.MemData_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0) begin
        n_err++; $display("FAIL idle_quiet: got req=%b stall=%b want req=0 stall=0", bus.mem_req_o, bus.stall_o);
      end
    end
  endtask
  task automatic test_load();
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL load_done: got %b want 1", done_seen); end
    n_cmp++; if (req_cycles != 3) begin n_err++; $display("FAIL load_req_cycles: got %0d want 3", req_cycles); end
    n_cmp++; if (stall_cycles != 4) begin n_err++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cycles); end
    n_cmp++; if (we_seen !== 1'b0) begin n_err++; $display("FAIL load_we: got %b want 0", we_seen); end
    n_cmp++; if (addr_seen !== 32'h40) begin n_err++; $display("FAIL load_addr: got %h want 00000040", addr_seen); end
    n_cmp++; if (done_md !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_memdata: got %h want deadbeef", done_md); end
    n_cmp++; if (err_cycles != 0) begin n_err++; $display("FAIL load_err: got %0d want 0", err_cycles); end
  endtask
  task automatic test_store();
    do_access(1'b1, 1'b1, 32'h80, 32'h12345678, 1, 32'hFFFFFFFF);
    n_cmp++; if (req_cycles != 1) begin n_err++; $display("FAIL store_req_cycles: got %0d want 1", req_cycles); end
    n_cmp++; if (stall_cycles != 2) begin n_err++; $display("FAIL store_stall_cycles: got %0d want 2", stall_cycles); end
    n_cmp++; if (we_seen !== 1'b1) begin n_err++; $display("FAIL store_we: got %b want 1", we_seen); end
    n_cmp++; if (wdata_seen !== 32'h12345678) begin n_err++; $display("FAIL store_wdata: got %h want 12345678", wdata_seen); end
    n_cmp++; if (addr_seen !== 32'h80) begin n_err++; $display("FAIL store_addr: got %h want 00000080", addr_seen); end
    n_cmp++; if (done_md !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_memdata: got %h want deadbeef", done_md); end
    n_cmp++; if (err_cycles != 0) begin n_err++; $display("FAIL store_err: got %0d want 0", err_cycles); end
  endtask
  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 32'h41, 32'h0, 1, 32'h11111111);
    n_cmp++; if (req_cycles != 0) begin n_err++; $display("FAIL mis_req_cycles: got %0d want 0", req_cycles); end
    n_cmp++; if (stall_cycles != 1) begin n_err++; $display("FAIL mis_stall_cycles: got %0d want 1", stall_cycles); end
    n_cmp++; if (done_err !== 1'b1) begin n_err++; $display("FAIL mis_err_in_done: got %b want 1", done_err); end
    n_cmp++; if (err_cycles != 1) begin n_err++; $display("FAIL mis_err_cycles: got %0d want 1", err_cycles); end
    n_cmp++; if (done_md !== 32'hDEADBEEF) begin n_err++; $display("FAIL mis_memdata: got %h want deadbeef", done_md); end
    @(negedge clk);
    n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL mis_err_pulse_end: got %b want 0", bus.err_o); end
  endtask
  task automatic test_timeout();
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h0);
    n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL to_done: got %b want 1", done_seen); end
    n_cmp++; if (req_cycles != 4) begin n_err++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    n_cmp++; if (stall_cycles != 5) begin n_err++; $display("FAIL to_stall_cycles: got %0d want 5", stall_cycles); end
    n_cmp++; if (done_err !== 1'b1) begin n_err++; $display("FAIL to_err_in_done: got %b want 1", done_err); end
    n_cmp++; if (err_cycles != 1) begin n_err++; $display("FAIL to_err_cycles: got %0d want 1", err_cycles); end
    n_cmp++; if (done_md !== 32'h0) begin n_err++; $display("FAIL to_memdata: got %h want 0", done_md); end
    @(posedge clk); #1;
    bus.MemRead_i = 1'b1; bus.Addr_i = 32'h48;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.mem_req_o !== 1'b1) begin n_err++; $display("FAIL rst_busy_req: got %b want 1", bus.mem_req_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
    @(posedge clk); #1;
    bus.MemRead_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req_drop: got %b want 0", bus.mem_req_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_idle: got req=%b stall=%b want req=0 stall=0", bus.mem_req_o, bus.stall_o);
    end
  endtask
  task automatic test_back_to_back();
    do_access(1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 2, 32'h0);
    n_cmp++; if (req_cycles != 2) begin n_err++; $display("FAIL buf_store_req_cycles: got %0d want 2", req_cycles); end
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h0BADF00D);
`ifdef MEM_LAST_BUF_EN
    n_cmp++; if (req_cycles != 0) begin n_err++; $display("FAIL buf_hit_req_cycles: got %0d want 0", req_cycles); end
    n_cmp++; if (stall_cycles != 1) begin n_err++; $display("FAIL buf_hit_stall_cycles: got %0d want 1", stall_cycles); end
    n_cmp++; if (done_md !== 32'hA5A5A5A5) begin n_err++; $display("FAIL buf_hit_memdata: got %h want a5a5a5a5", done_md); end
`else
    n_cmp++; if (req_cycles != 1) begin n_err++; $display("FAIL nobuf_req_cycles: got %0d want 1", req_cycles); end
    n_cmp++; if (stall_cycles != 2) begin n_err++; $display("FAIL nobuf_stall_cycles: got %0d want 2", stall_cycles); end
    n_cmp++; if (done_md !== 32'h0BADF00D) begin n_err++; $display("FAIL nobuf_memdata: got %h want 0badf00d", done_md); end
`endif
    n_cmp++; if (err_cycles != 0) begin n_err++; $display("FAIL buf_err: got %0d want 0", err_cycles); end
  endtask
  initial begin
    bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b0; bus.Addr_i = '0; bus.WriteData_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access controller for the 5-stage pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the EX/MEM control and data fields and runs a request/acknowledge transaction to a variable-latency data memory.
- Stalls the upstream pipeline until the transaction completes, then presents load data for MEM/WB to capture on the following clock edge.

Parameters:
- ADDR_W, 32, width of the address presented to data memory (low ADDR_W bits of Addr_i).
- TIMEOUT, 255, maximum BUSY cycles without acknowledge before the access is aborted (1..65535).

Ports:
- clk_i  in  1  clock; all state changes on posedge.
- rst_i  in  1  synchronous, active-high reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- Addr_i  in  32  byte address from EX/MEM ALU result.
- WriteData_i  in  32  store data from EX/MEM.
- mem_req_o  out  1  transaction request to data memory.
- mem_we_o  out  1  1 = write transaction, 0 = read transaction.
- mem_addr_o  out  ADDR_W  transaction address.
- mem_wdata_o  out  32  transaction write data.
- mem_ack_i  in  1  memory completion; read data valid in the same cycle.
- mem_rdata_i  in  32  memory read data.
- MemData_o  out  32  load result to MEM/WB MemData input.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- err_o  out  1  one-cycle pulse on a misaligned or timed-out access.

Behaviour:
- Reset values (rst_i is synchronous and active-high and sampled on the clk_i posedge): state IDLE; mem_req_o, mem_we_o, err_o = 0; mem_addr_o, mem_wdata_o, MemData_o = 0; timeout counter = 0.
- If rst_i is asserted mid-transaction, it abandons the access: mem_req_o drops on the next edge. Memory must tolerate a dropped request.
- Access detection: access = MemRead_i | MemWrite_i. If both are high, the access is a write and MemRead_i is ignored.
- stall_o is combinational:
  - 1 in IDLE when access=1.
  - 1 in BUSY.
  - 0 in DONE.
  - 0 during reset.
- IDLE state:
  - If access=1 and Addr_i[1:0]!=0, go to DONE. err_o pulses in the DONE cycle. No memory request is issued and MemData_o is unchanged.
  - Else if access=1, go to BUSY. At that edge, mem_req_o=1, mem_we_o=MemWrite_i, mem_addr_o=Addr_i[ADDR_W-1:0], mem_wdata_o=WriteData_i, and counter=0.
  - Else stay in IDLE.
- BUSY state:
  - mem_req_o and the address/data/we outputs are held constant.
  - On mem_ack_i=1, go to DONE and drop mem_req_o. For a read, MemData_o is loaded with mem_rdata_i.
  - Else if counter==TIMEOUT-1, go to DONE, drop mem_req_o, set MemData_o=0, and pulse err_o in the DONE cycle.
  - Else increment the counter.
- DONE state:
  - Lasts exactly one cycle and always returns to IDLE.
  - stall_o=0, so EX/MEM advances and MEM/WB captures MemData_o at the end of this cycle.
  - The inputs still hold the same instruction, so no new access starts in DONE.
- mem_ack_i is ignored outside BUSY.
- MemData_o is held between loads; writes never change it.
- Latency: with the access seen in cycle 0 and ack in cycle k (k>=1), stall_o is high in cycles 0..k and DONE is cycle k+1. The minimum is 2 stall cycles.

Optional Feature:
- Macro: MEM_LAST_BUF_EN.
- Defined: adds a one-entry last-access buffer (tag, data, valid). valid is cleared by reset and by a timeout.
  - Buffer updates: a completed write loads tag=mem_addr_o, data=mem_wdata_o, valid=1. A completed read loads tag=mem_addr_o, data=mem_rdata_i, valid=1.
  - Read hit: an aligned read in IDLE with valid=1 and a matching tag issues no request. The block goes straight to DONE with MemData_o = buffered data. stall_o is high only in cycle 0.
  - Writes always go to memory.
- Not defined: no buffer; every aligned access issues a memory transaction.

Test Plan:
1. Reset then idle: rst_i=1 for 2 cycles, no access -> all outputs 0, stall_o=0, mem_req_o never rises.
2. Load, ack latency 3: MemRead_i=1, Addr_i=0x40, memory acks 3 cycles after req with 0xDEADBEEF -> mem_req_o high 3 cycles; stall_o high 4 cycles; in DONE, MemData_o=0xDEADBEEF and stall_o=0.
3. Store with ack at 1st req cycle: MemWrite_i=1 (MemRead_i=1 too), Addr_i=0x80, WriteData_i=0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o high 2 cycles, MemData_o unchanged, err_o=0.
4. Misaligned access: MemRead_i=1, Addr_i=0x41 -> no mem_req_o, stall_o high 1 cycle, err_o pulses 1 cycle in DONE, MemData_o unchanged.
5. Timeout and reset: with TIMEOUT=4 and no ack -> mem_req_o high exactly 4 cycles, then DONE with err_o=1 and MemData_o=0. Repeat with rst_i asserted in the 2nd BUSY cycle -> IDLE and mem_req_o=0 next cycle.
6. (MEM_LAST_BUF_EN) Store 0xA5A5A5A5 to 0x100, then load 0x100 -> load issues no mem_req_o, stall_o high 1 cycle, MemData_o=0xA5A5A5A5. Without the macro -> the load issues a request.
